// File: rtl/tb_clock_pkg.sv
// Shared types and constants for the multi-channel cycle-based clock generator.
// The optional jitter feature is controlled by the TB_CLOCK_JITTER_EN macro.
package tb_clock_pkg;

    // Per-channel FSM state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OFFSET = 2'd1,
        ST_LOW    = 2'd2,
        ST_HIGH   = 2'd3
    } chan_state_t;

    // Per-channel mode flags, kept together in shadow and active copies
    typedef struct packed {
        logic invert;
        logic jitter;
    } chan_flags_t;

    // Channel configuration after reset
    localparam int RST_OFFSET = 0;
    localparam int RST_PERIOD = 2;
    localparam int RST_LOW    = 1;

    // 16-bit maximal Galois LFSR (x^16 + x^14 + x^13 + x^11 + 1)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/tb_clock_chan.sv
// One generated-clock channel: shadow/active configuration, phase FSM and
// down-counter. With TB_CLOCK_JITTER_EN defined, a per-channel LFSR may
// stretch each LOW/HIGH phase by one cycle.
module tb_clock_chan
    import tb_clock_pkg::*;
#(
    parameter int          CW   = 16,
    parameter logic [15:0] SEED = LFSR_SEED
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          run,
    input  logic          run_rise,
    input  logic          wr,
    input  logic [CW-1:0] wr_offset,
    input  logic [CW-1:0] wr_period,
    input  logic [CW-1:0] wr_low,
    input  logic          wr_invert,
    input  logic          wr_jitter,
    output logic          clk_out,
    output logic          ch_active
);

    localparam logic [CW-1:0] ONE = CW'(1);

    chan_state_t   state;
    logic [CW-1:0] cnt;
    logic          stop_q;

    logic [CW-1:0] sh_offset;
    logic [CW-1:0] sh_period;
    logic [CW-1:0] sh_low;
    chan_flags_t   sh_flags;

    logic [CW-1:0] act_period;
    logic [CW-1:0] act_low;
    chan_flags_t   act_flags;

    logic          go_offset;
    logic          go_low;
    logic          go_high;
    logic          go_idle;
    logic          ext_low;
    logic          ext_high;
    logic [CW-1:0] low_load;
    logic [CW-1:0] high_load;

`ifdef TB_CLOCK_JITTER_EN
    logic [15:0] lfsr;

    // LFSR steps on every LOW or HIGH entry, whether or not jitter is enabled
    always_ff @(posedge CLK) begin
        if (RST) begin
            lfsr <= SEED;
        end else if (go_low || go_high) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    // LOW uses the flag being loaded, HIGH the flag already active this period
    assign ext_low  = sh_flags.jitter & lfsr[0];
    assign ext_high = act_flags.jitter & lfsr[0];
`else
    logic unused_jitter;
    assign unused_jitter = act_flags.jitter ^ (^SEED);
    assign ext_low       = 1'b0;
    assign ext_high      = 1'b0;
`endif

    // Counter load values: phase length minus one, plus optional jitter cycle
    always_comb begin
        low_load  = sh_low - ONE + {{(CW-1){1'b0}}, ext_low};
        high_load = act_period - act_low - ONE + {{(CW-1){1'b0}}, ext_high};
    end

    // Next-phase decisions; a phase ends when its counter reaches zero
    always_comb begin
        go_offset = 1'b0;
        go_low    = 1'b0;
        go_high   = 1'b0;
        go_idle   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_rise) begin
                    if (sh_offset == '0) go_low    = 1'b1;
                    else                 go_offset = 1'b1;
                end
            end
            ST_OFFSET: begin
                if (cnt == '0) go_low = 1'b1;
            end
            ST_LOW: begin
                if (cnt == '0) go_high = 1'b1;
            end
            ST_HIGH: begin
                if (cnt == '0) begin
                    if (run && !stop_q) go_low  = 1'b1;
                    else                go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase
    end

    // Shadow registers take every validated write for this channel
    always_ff @(posedge CLK) begin
        if (RST) begin
            sh_offset <= CW'(RST_OFFSET);
            sh_period <= CW'(RST_PERIOD);
            sh_low    <= CW'(RST_LOW);
            sh_flags  <= '0;
        end else if (wr) begin
            sh_offset <= wr_offset;
            sh_period <= wr_period;
            sh_low    <= wr_low;
            sh_flags  <= '{invert: wr_invert, jitter: wr_jitter};
        end
    end

    // Phase FSM; active configuration is captured from shadow on each LOW entry
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            act_period <= CW'(RST_PERIOD);
            act_low    <= CW'(RST_LOW);
            act_flags  <= '0;
        end else if (go_low) begin
            state      <= ST_LOW;
            cnt        <= low_load;
            act_period <= sh_period;
            act_low    <= sh_low;
            act_flags  <= sh_flags;
        end else if (go_offset) begin
            state <= ST_OFFSET;
            cnt   <= sh_offset - ONE;
        end else if (go_high) begin
            state <= ST_HIGH;
            cnt   <= high_load;
        end else if (go_idle) begin
            state <= ST_IDLE;
        end else if (state != ST_IDLE) begin
            cnt <= cnt - ONE;
        end
    end

    // Remember a run drop so a brief re-assert cannot extend the drain
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_q <= 1'b0;
        end else if (go_idle || state == ST_IDLE) begin
            stop_q <= 1'b0;
        end else if (!run) begin
            stop_q <= 1'b1;
        end
    end

    assign clk_out   = (state != ST_LOW) ^ act_flags.invert;
    assign ch_active = (state != ST_IDLE);

endmodule

// File: rtl/tb_clock_gen_multi.sv
// Multi-channel cycle-based clock/strobe generator. Holds run-edge detection,
// configuration write decode/validation and the reject pulse; the channels do
// the waveform generation. Optional jitter: define TB_CLOCK_JITTER_EN.
module tb_clock_gen_multi
    import tb_clock_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [1:0]     tb_status,
    input  logic           cfg_wr,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_offset,
    input  logic [CW-1:0]  cfg_period,
    input  logic [CW-1:0]  cfg_low,
    input  logic           cfg_invert,
    input  logic           cfg_jitter,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] ch_active,
    output logic           cfg_err
);

    logic           run;
    logic           run_q;
    logic           run_rise;
    logic           cfg_bad;
    logic [NCH-1:0] ch_wr;
    logic           unused_status;

    assign run           = tb_status[0];
    assign unused_status = tb_status[1];
    assign run_rise      = run & ~run_q;

    // Previous run sample for rising-edge detection
    always_ff @(posedge CLK) begin
        if (RST) run_q <= 1'b0;
        else     run_q <= run;
    end

    // A write is rejected if any phase would be empty or the channel is absent
    always_comb begin
        cfg_bad = (cfg_period == '0) || (cfg_low == '0) ||
                  (cfg_low >= cfg_period) || (32'(cfg_ch) >= 32'(NCH));
    end

    // One-cycle reject pulse, aligned with the shadow update of a good write
    always_ff @(posedge CLK) begin
        if (RST) cfg_err <= 1'b0;
        else     cfg_err <= cfg_wr & cfg_bad;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign ch_wr[i] = cfg_wr & ~cfg_bad & (cfg_ch == CHW'(i));

        tb_clock_chan #(
            .CW   (CW),
            .SEED (LFSR_SEED ^ 16'(i))
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .run       (run),
            .run_rise  (run_rise),
            .wr        (ch_wr[i]),
            .wr_offset (cfg_offset),
            .wr_period (cfg_period),
            .wr_low    (cfg_low),
            .wr_invert (cfg_invert),
            .wr_jitter (cfg_jitter),
            .clk_out   (clk_out[i]),
            .ch_active (ch_active[i])
        );
    end

endmodule

// File: tb/tb_tb_clock_gen_multi.sv
// Self-checking bench for tb_clock_gen_multi. The reference model expands each
// channel's configuration into a queue of expected output samples.
module tb_tb_clock_gen_multi;

    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int CHW = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic [1:0]     tb_status;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_offset;
    logic [CW-1:0]  cfg_period;
    logic [CW-1:0]  cfg_low;
    logic           cfg_invert;
    logic           cfg_jitter;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] ch_active;
    logic           cfg_err;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    tb_clock_gen_multi #(.NCH(NCH), .CW(CW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .tb_status  (tb_status),
        .cfg_wr     (cfg_wr),
        .cfg_ch     (cfg_ch),
        .cfg_offset (cfg_offset),
        .cfg_period (cfg_period),
        .cfg_low    (cfg_low),
        .cfg_invert (cfg_invert),
        .cfg_jitter (cfg_jitter),
        .clk_out    (clk_out),
        .ch_active  (ch_active),
        .cfg_err    (cfg_err)
    );

    // Reference model state
    bit          m_idle [NCH];
    bit          m_stop [NCH];
    bit          m_inoff[NCH];
    bit          q      [NCH][$];
    int          s_off  [NCH];
    int          s_per  [NCH];
    int          s_low  [NCH];
    bit          s_inv  [NCH];
    bit          s_jit  [NCH];
    bit          a_inv  [NCH];
    bit          m_run_q;
    bit          e_err;
`ifdef TB_CLOCK_JITTER_EN
    logic [15:0] lfsr   [NCH];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction
`endif

    function automatic logic [2*NCH:0] expv();
        logic [NCH-1:0] c;
        logic [NCH-1:0] a;
        for (int ch = 0; ch < NCH; ch++) begin
            a[ch] = !m_idle[ch];
            c[ch] = (m_idle[ch] ? 1'b1 : q[ch][0]) ^ a_inv[ch];
        end
        return {e_err, a, c};
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_idle[ch]  = 1'b1;
            m_stop[ch]  = 1'b0;
            m_inoff[ch] = 1'b0;
            q[ch].delete();
            s_off[ch] = 0; s_per[ch] = 2; s_low[ch] = 1;
            s_inv[ch] = 1'b0; s_jit[ch] = 1'b0; a_inv[ch] = 1'b0;
`ifdef TB_CLOCK_JITTER_EN
            lfsr[ch] = 16'hACE1 ^ 16'(ch);
`endif
        end
        m_run_q = 1'b0;
        e_err   = 1'b0;
    endtask

    // Expand one LOW+HIGH period from the shadow configuration
    task automatic gen_period(input int ch);
        int lo;
        int hi;
        lo = s_low[ch];
        hi = s_per[ch] - s_low[ch];
`ifdef TB_CLOCK_JITTER_EN
        if (s_jit[ch]) lo += int'(lfsr[ch][0]);
        lfsr[ch] = lfsr_step(lfsr[ch]);
        if (s_jit[ch]) hi += int'(lfsr[ch][0]);
        lfsr[ch] = lfsr_step(lfsr[ch]);
`endif
        a_inv[ch] = s_inv[ch];
        for (int k = 0; k < lo; k++) q[ch].push_back(1'b0);
        for (int k = 0; k < hi; k++) q[ch].push_back(1'b1);
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT
    task automatic cyc();
        bit run;
        bit rise;
        bit ok;
        run  = tb_status[0];
        rise = run && !m_run_q;
        ok   = !(cfg_period == 0 || cfg_low == 0 || cfg_low >= cfg_period);
        for (int ch = 0; ch < NCH; ch++) begin
            if (m_idle[ch]) begin
                if (rise) begin
                    m_idle[ch] = 1'b0;
                    m_stop[ch] = 1'b0;
                    if (s_off[ch] == 0) begin
                        gen_period(ch);
                    end else begin
                        for (int k = 0; k < s_off[ch]; k++) q[ch].push_back(1'b1);
                        m_inoff[ch] = 1'b1;
                    end
                end
            end else begin
                if (!run) m_stop[ch] = 1'b1;
                void'(q[ch].pop_front());
                if (q[ch].size() == 0) begin
                    if (m_inoff[ch]) begin
                        m_inoff[ch] = 1'b0;
                        gen_period(ch);
                    end else if (run && !m_stop[ch]) begin
                        gen_period(ch);
                    end else begin
                        m_idle[ch] = 1'b1;
                    end
                end
            end
        end
        if (cfg_wr && ok) begin
            s_off[cfg_ch] = int'(cfg_offset);
            s_per[cfg_ch] = int'(cfg_period);
            s_low[cfg_ch] = int'(cfg_low);
            s_inv[cfg_ch] = cfg_invert;
            s_jit[cfg_ch] = cfg_jitter;
        end
        e_err   = cfg_wr && !ok;
        m_run_q = run;
        @(posedge CLK);
        #1;
        cfg_wr = 1'b0;
    endtask

    task automatic set_cfg(input int ch, input int off, input int per, input int low,
                           input bit inv, input bit jit);
        cfg_wr     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_offset = CW'(off);
        cfg_period = CW'(per);
        cfg_low    = CW'(low);
        cfg_invert = inv;
        cfg_jitter = jit;
    endtask

    task automatic test_reset();
        RST = 1'b1; tb_status = 2'b00; cfg_wr = 1'b0; cfg_ch = '0;
        cfg_offset = '0; cfg_period = '0; cfg_low = '0; cfg_invert = 1'b0; cfg_jitter = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        model_reset();
        total++;
        if ({cfg_err, ch_active, clk_out} !== 9'h00F) begin
            bad++;
            $display("FAIL reset_state got=%h want=%h", {cfg_err, ch_active, clk_out}, 9'h00F);
        end
        RST = 1'b0;
        tb_status = 2'b10;
        for (int k = 0; k < 10; k++) begin
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== 9'h00F) begin
                bad++;
                $display("FAIL idle_after_reset k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, 9'h00F);
            end
        end
    endtask

    task automatic test_basic();
        int  first_low;
        int  last_fall;
        logic prev;
        set_cfg(0, 3, 5, 2, 1'b0, 1'b0);
        cyc();
        total++;
        if ({cfg_err, ch_active, clk_out} !== expv()) begin
            bad++;
            $display("FAIL basic_cfg got=%h want=%h", {cfg_err, ch_active, clk_out}, expv());
        end
        tb_status = 2'b01;
        first_low = -1; last_fall = -1; prev = clk_out[0];
        for (int k = 1; k <= 110; k++) begin
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL basic k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
            if (clk_out[0] === 1'b0 && first_low < 0) first_low = k;
            if (prev === 1'b1 && clk_out[0] === 1'b0) begin
                if (last_fall >= 0) begin
                    total++;
                    if (k - last_fall != 5) begin
                        bad++;
                        $display("FAIL basic_period k=%0d got=%0d want=5", k, k - last_fall);
                    end
                end
                last_fall = k;
            end
            prev = clk_out[0];
        end
        total++;
        if (first_low != 4) begin
            bad++;
            $display("FAIL basic_first_low got=%0d want=4", first_low);
        end
    endtask

    task automatic test_invalid();
        int per [3] = '{4, 0, 5};
        int low [3] = '{4, 1, 0};
        for (int w = 0; w < 3; w++) begin
            set_cfg(0, 1, per[w], low[w], 1'b1, 1'b0);
            cyc();
            total++;
            if (cfg_err !== 1'b1) begin
                bad++;
                $display("FAIL invalid_err w=%0d got=%b want=1", w, cfg_err);
            end
            for (int k = 0; k < 12; k++) begin
                cyc();
                total++;
                if ({cfg_err, ch_active, clk_out} !== expv()) begin
                    bad++;
                    $display("FAIL invalid w=%0d k=%0d got=%h want=%h", w, k, {cfg_err, ch_active, clk_out}, expv());
                end
            end
        end
    endtask

    task automatic test_two_chan();
        int   n;
        int   last_fall;
        int   intv;
        logic prev;
        tb_status = 2'b00;
        n = 0;
        while (ch_active !== '0 && n < 200) begin
            cyc();
            n++;
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL two_drain n=%0d got=%h want=%h", n, {cfg_err, ch_active, clk_out}, expv());
            end
        end
        total++;
        if (ch_active !== '0) begin
            bad++;
            $display("FAIL two_drain_timeout got=%b want=0", ch_active);
        end
        set_cfg(1, 0, 6, 3, 1'b1, 1'b0); cyc();
        for (int ch = 2; ch < NCH; ch++) begin
            int p;
            p = int'($urandom_range(2, 12));
            set_cfg(ch, int'($urandom_range(0, 5)), p, int'($urandom_range(1, p - 1)),
                    1'($urandom_range(0, 1)), 1'b0);
            cyc();
        end
        tb_status = 2'b01;
        last_fall = -1; intv = 0; prev = clk_out[0];
        for (int k = 0; k < 130; k++) begin
            if (k == 40) set_cfg(0, 3, 8, 2, 1'b0, 1'b0);
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL two_chan k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
            if (prev === 1'b1 && clk_out[0] === 1'b0) begin
                if (last_fall >= 0) intv = k - last_fall;
                last_fall = k;
            end
            prev = clk_out[0];
        end
        total++;
        if (intv != 8) begin
            bad++;
            $display("FAIL two_chan_new_period got=%0d want=8", intv);
        end
    endtask

    task automatic test_stop();
        int n;
        n = 0;
        while (clk_out[0] !== 1'b0 && n < 50) begin
            cyc();
            n++;
        end
        total++;
        if (clk_out[0] !== 1'b0) begin
            bad++;
            $display("FAIL stop_find_low got=%b want=0", clk_out[0]);
        end
        tb_status = 2'b00;
        for (int k = 0; k < 42; k++) begin
            cyc();
            tb_status = 2'b01;
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL stop k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
        end
        total++;
        if (ch_active[0] !== 1'b0 || clk_out[0] !== 1'b1) begin
            bad++;
            $display("FAIL stop_idle got=%b%b want=01", ch_active[0], clk_out[0]);
        end
        tb_status = 2'b00;
        cyc();
        tb_status = 2'b01;
        for (int k = 0; k < 20; k++) begin
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL restart k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
        end
        total++;
        if (ch_active[0] !== 1'b1) begin
            bad++;
            $display("FAIL restart_active got=%b want=1", ch_active[0]);
        end
    endtask

    task automatic test_jitter();
        int   n;
        int   last_fall;
        logic prev;
        tb_status = 2'b00;
        n = 0;
        while (ch_active !== '0 && n < 200) begin
            cyc();
            n++;
        end
        total++;
        if (ch_active !== '0) begin
            bad++;
            $display("FAIL jit_drain_timeout got=%b want=0", ch_active);
        end
        set_cfg(3, 1, 10, 4, 1'b0, 1'b1);
        cyc();
        tb_status = 2'b01;
        last_fall = -1; prev = clk_out[3];
        for (int k = 0; k < 200; k++) begin
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL jitter k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
            if (prev === 1'b1 && clk_out[3] === 1'b0) begin
                if (last_fall >= 0) begin
                    total++;
`ifdef TB_CLOCK_JITTER_EN
                    if (k - last_fall < 10 || k - last_fall > 12) begin
                        bad++;
                        $display("FAIL jitter_period got=%0d want=10..12", k - last_fall);
                    end
`else
                    if (k - last_fall != 10) begin
                        bad++;
                        $display("FAIL exact_period got=%0d want=10", k - last_fall);
                    end
`endif
                end
                last_fall = k;
            end
            prev = clk_out[3];
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                set_cfg(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 12)), int'($urandom_range(0, 12)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 29) == 0) tb_status[0] = ~tb_status[0];
            cyc();
            total++;
            if ({cfg_err, ch_active, clk_out} !== expv()) begin
                bad++;
                $display("FAIL random k=%0d got=%h want=%h", k, {cfg_err, ch_active, clk_out}, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_two_chan();
        test_stop();
        test_jitter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
